// File: rtl/amm_pkg.sv
// Shared types and defaults for the amaster_mm MM initiator.
package amm_pkg;

  localparam int AMM_ADDRW = 8;
  localparam int AMM_DATAW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } amm_state_t;

  typedef struct packed {
    logic                 write;
    logic                 err;
    logic [AMM_DATAW-1:0] rdata;
  } amm_rsp_t;

endpackage

// File: rtl/amm_timeout_cnt.sv
// Stall counter for amaster_mm: clears on clr, counts enabled cycles and
// raises hit on the enabled cycle that makes the count reach TIMEOUT.
module amm_timeout_cnt #(
  parameter int TOW     = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [TOW-1:0] LAST = TOW'(TIMEOUT - 1);

  logic [TOW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the stalls seen before this cycle; this stall is number cnt+1
  assign hit = en && (cnt == LAST);

endmodule

// File: rtl/amaster_mm.sv
// Avalon-MM style single-transfer initiator: local cmd/rsp handshake to
// basic MM read/write. Optional stall abort via AMASTER_MM_TIMEOUT_EN.
module amaster_mm
  import amm_pkg::*;
#(
  parameter int ADDRW   = AMM_ADDRW,
  parameter int DATAW   = AMM_DATAW,
  parameter int TOW     = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [ADDRW-1:0] cmd_addr,
  input  logic [DATAW-1:0] cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_write,
  output logic [DATAW-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [ADDRW-1:0] m_addr,
  output logic             m_read,
  output logic             m_write,
  output logic [DATAW-1:0] m_writedata,
  input  logic [DATAW-1:0] m_readdata,
  input  logic             m_waitrequest
);

  amm_state_t state;
  logic       to_hit;

  assign cmd_ready = (state == IDLE);

`ifdef AMASTER_MM_TIMEOUT_EN
  amm_timeout_cnt #(
    .TOW     (TOW),
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != BUS),
    .en  ((state == BUS) && m_waitrequest),
    .hit (to_hit)
  );
`else
  logic [TOW-1:0] unused_timeout;
  assign unused_timeout = TOW'(TIMEOUT);
  assign to_hit         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      m_addr      <= '0;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_writedata <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            m_addr      <= cmd_addr;
            m_writedata <= cmd_write ? cmd_wdata : '0;
            m_write     <= cmd_write;
            m_read      <= !cmd_write;
            state       <= BUS;
          end
        end
        BUS: begin
          // A release in the same cycle as the timeout hit completes normally
          if (!m_waitrequest) begin
            m_read    <= 1'b0;
            m_write   <= 1'b0;
            rsp_rdata <= m_read ? m_readdata : '0;
            rsp_write <= m_write;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (to_hit) begin
            m_read    <= 1'b0;
            m_write   <= 1'b0;
            rsp_rdata <= '0;
            rsp_write <= m_write;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amaster_mm.sv
// Self-checking bench for amaster_mm: directed and randomized transfers
// against a transaction-level reference model of the initiator.
module tb_amaster_mm;

  localparam int ADDRW   = 8;
  localparam int DATAW   = 32;
  localparam int TOW     = 8;
  localparam int TIMEOUT = 4;
`ifdef AMASTER_MM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [ADDRW-1:0] cmd_addr;
  logic [DATAW-1:0] cmd_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_write;
  logic [DATAW-1:0] rsp_rdata;
  logic             rsp_err;
  logic [ADDRW-1:0] m_addr;
  logic             m_read;
  logic             m_write;
  logic [DATAW-1:0] m_writedata;
  logic [DATAW-1:0] m_readdata;
  logic             m_waitrequest;

  int checks   = 0;
  int failures = 0;

  amaster_mm #(
    .ADDRW   (ADDRW),
    .DATAW   (DATAW),
    .TOW     (TOW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .m_addr        (m_addr),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .m_waitrequest (m_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level expectation: what the response must be and how many
  // cycles the strobe must stay up, given the slave's stall count.
  typedef struct {
    logic        write;
    logic        err;
    logic [31:0] rdata;
    int          bus_cycles;
  } exp_t;

  function automatic exp_t model(input logic w, input int waits, input logic [31:0] rd);
    exp_t e;
    e.write      = w;
    e.err        = TO_EN && (waits >= TIMEOUT);
    e.rdata      = (w || e.err) ? 32'h0 : rd;
    e.bus_cycles = e.err ? TIMEOUT : waits + 1;
    return e;
  endfunction

  task automatic run_txn(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] rd, input int stall);
    exp_t e;
    e = model(w, waits, rd);
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid     = 1'b1;
    cmd_write     = w;
    cmd_addr      = a;
    cmd_wdata     = d;
    rsp_ready     = 1'b0;
    m_waitrequest = 1'($urandom);
    for (int i = 0; i < e.bus_cycles; i++) begin
      @(negedge clk);
      if (i == 0) begin
        cmd_valid = 1'b0;
        cmd_addr  = 8'($urandom);
        cmd_wdata = $urandom;
      end
      m_waitrequest = (i < waits);
      m_readdata    = (i < waits) ? $urandom : rd;
      chk("m_write", 32'(m_write), 32'(w));
      chk("m_read", 32'(m_read), 32'(!w));
      chk("m_addr", 32'(m_addr), 32'(a));
      chk("m_writedata", m_writedata, w ? d : 32'h0);
      chk("bus_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("bus_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      m_waitrequest = 1'($urandom);
      m_readdata    = $urandom;
      rsp_ready     = (s == stall);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_write", 32'(rsp_write), 32'(e.write));
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("resp_strobes", 32'({m_read, m_write}), 32'd0);
      chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [6:0] strobe_seen;
    int         overlap;
    int         rsp_seen;

    rst           = 1'b1;
    cmd_valid     = 1'b0;
    cmd_write     = 1'b0;
    cmd_addr      = '0;
    cmd_wdata     = '0;
    rsp_ready     = 1'b0;
    m_readdata    = '0;
    m_waitrequest = 1'b0;

    // Reset state, and no capture while rst is high
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_strobes", 32'({m_read, m_write}), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_write, rsp_err}), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_m_wdata", m_writedata, 32'h0);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    @(negedge clk);
    chk("rst_no_capture", 32'({m_read, m_write}), 32'd0);
    cmd_valid = 1'b0;
    rst       = 1'b0;

    // Directed transfers
    run_txn(1'b1, 8'h10, 32'hDEADBEEF, 0, 32'h0, 0);
    run_txn(1'b0, 8'h24, 32'h12345678, 3, 32'hCAFEF00D, 0);
    run_txn(1'b0, 8'hFF, 32'h0, 0, 32'hA5A5A5A5, 5);
    run_txn(1'b1, 8'h00, 32'hFFFFFFFF, 2, 32'h0, 5);

    // Randomized transfers; stalls beyond TIMEOUT exercise the abort path
    for (int t = 0; t < 16; t++) begin
      run_txn(1'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 6)),
              $urandom, int'($urandom_range(0, 3)));
    end

    // Reset in BUS while stalled: strobe drops at once, no response follows
    @(negedge clk);
    cmd_valid     = 1'b1;
    cmd_write     = 1'b0;
    cmd_addr      = 8'h33;
    m_waitrequest = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_rst_m_read", 32'(m_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_m_read", 32'(m_read), 32'd0);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst           = 1'b0;
    m_waitrequest = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rsp_seen += int'(rsp_valid) + int'(m_read) + int'(m_write);
    end
    chk("post_rst_quiet", 32'(rsp_seen), 32'd0);
    run_txn(1'b0, 8'h34, 32'h0, 1, 32'h0BADF00D, 1);

`ifdef AMASTER_MM_TIMEOUT_EN
    // Stuck slave: abort on the TIMEOUT-th stall edge with rsp_err
    run_txn(1'b0, 8'h55, 32'h0, 50, 32'h11111111, 0);
    run_txn(1'b1, 8'h56, 32'h87654321, TIMEOUT - 1, 32'h0, 0);
`else
    // Stuck slave without timeout: BUS holds indefinitely
    @(negedge clk);
    cmd_valid     = 1'b1;
    cmd_write     = 1'b0;
    cmd_addr      = 8'h55;
    m_waitrequest = 1'b1;
    rsp_ready     = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rsp_seen += int'(rsp_valid);
    end
    chk("no_timeout_rsp", 32'(rsp_seen), 32'd0);
    chk("no_timeout_m_read", 32'(m_read), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    rsp_ready     = 1'b0;
    m_waitrequest = 1'b0;
`endif

    // Back-to-back with cmd_valid held and rsp_ready held high
    @(negedge clk);
    rsp_ready     = 1'b1;
    m_waitrequest = 1'b0;
    cmd_valid     = 1'b1;
    cmd_write     = 1'b1;
    cmd_addr      = 8'h40;
    cmd_wdata     = 32'h01020304;
    strobe_seen   = '0;
    overlap       = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      strobe_seen[c] = m_read | m_write;
      overlap += int'(m_read & m_write);
      if (c == 0) begin
        chk("b2b_first_write", 32'(m_write), 32'd1);
        cmd_write = 1'b0;
        cmd_addr  = 8'h41;
      end
      if (c == 3) begin
        chk("b2b_second_read", 32'(m_read), 32'd1);
        chk("b2b_second_addr", 32'(m_addr), 32'h41);
        cmd_valid = 1'b0;
      end
    end
    chk("b2b_strobe_pattern", 32'(strobe_seen), 32'b0001001);
    chk("b2b_no_overlap", 32'(overlap), 32'd0);
    rsp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/amaster_mm.md
Name: amaster_mm

Overview:
Avalon-MM style initiator (master) that turns single commands from a local command/response handshake into basic, non-pipelined MM read/write transfers. It is the counterpart of the team's MM register slave: the slave sits on the m_* bus side of this block. It honours waitrequest on both reads and writes, returns read data and completion status, and optionally aborts stalled transfers on timeout.

Parameters:
ADDRW, 8, MM address width
DATAW, 32, MM data width
TOW, 8, timeout counter width
TIMEOUT, 255, max consecutive waitrequest cycles before abort (1..2^TOW-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDRW  target address
cmd_wdata  in  DATAW  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATAW  read data (0 for writes and errors)
rsp_err  out  1  transfer aborted by timeout
m_addr  out  ADDRW  MM address
m_read  out  1  MM read strobe
m_write  out  1  MM write strobe
m_writedata  out  DATAW  MM write data
m_readdata  in  DATAW  MM read data
m_waitrequest  in  1  slave stall

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; it clears all state immediately, independent of clk.
- Registered outputs reset to 0: m_addr, m_read, m_write, m_writedata, rsp_valid, rsp_write, rsp_rdata, rsp_err. State resets to IDLE.
- cmd_ready = (state==IDLE), combinational. It reads 1 during reset, but no command is captured while rst is high.
- FSM states: IDLE, BUS, RESP.
- IDLE: on cmd_valid&&cmd_ready at an edge, capture addr/wdata/write and go to BUS. In the next cycle, m_read or m_write (exactly one) is high with m_addr and m_writedata driven. m_writedata is 0 for reads.
- BUS: all m_* outputs are held stable while m_waitrequest=1. The transfer completes at the first edge with m_waitrequest=0.
  - On completion: drop the strobe, capture m_readdata into rsp_rdata (reads only; 0 for writes), set rsp_write, set rsp_err=0, go to RESP.
- RESP: rsp_valid=1, and rsp_* are held until rsp_ready=1 at an edge. Then rsp_valid=0 and go to IDLE.
  - A new command is accepted no earlier than the cycle after the response handshake.
- Latency: command accepted at edge N, strobe visible in cycle N+1. With zero wait states the transfer completes at edge N+1 and rsp_valid is visible in cycle N+2. Each waitrequest cycle adds 1. Peak throughput is 1 transfer per 3 cycles.
- m_read and m_write are never both high. Neither is high outside BUS.
- If m_waitrequest=1 in IDLE or RESP, it is ignored.
- If rsp_ready is held high permanently, RESP lasts exactly 1 cycle.
- Reset mid-transfer drops the strobes in the same instant; the transaction is discarded and produces no response.
- Address and data pass through unmodified; no alignment or range checking is done.

Optional Feature:
Macro AMASTER_MM_TIMEOUT_EN.
- Defined:
  - A TOW-bit counter clears on entry to BUS and increments each BUS cycle with m_waitrequest=1.
  - When the counter equals TIMEOUT while waitrequest is still 1, that edge aborts the transfer: strobes drop, rsp_err=1, rsp_rdata=0, go to RESP.
  - A completion with m_waitrequest=0 in the same cycle as the counter reaching TIMEOUT wins (normal completion, rsp_err=0).
- Undefined: no counter is built, BUS waits indefinitely, and rsp_err is constant 0.

Decomposition:
- Package amm_pkg:
  - FSM state typedef (IDLE/BUS/RESP).
  - Default ADDRW/DATAW localparams.
  - Response field typedef (write, err, rdata).
- Sub-module amm_timeout_cnt: clear/enable/threshold counter with a hit output, instantiated only under AMASTER_MM_TIMEOUT_EN.

Test Plan:
- Write, zero wait: cmd addr=0x10, wdata=0xDEADBEEF, write=1 -> m_write=1 for 1 cycle with those values; rsp_valid one cycle later with rsp_write=1, rsp_err=0, rsp_rdata=0.
- Read with 3 waitrequest cycles, m_readdata=0xCAFEF00D on release -> m_read high 4 cycles with m_addr stable; rsp_rdata=0xCAFEF00D, rsp_valid in cycle N+5.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_* held constant and cmd_ready=0 throughout; new cmd accepted the cycle after the handshake.
- Reset asserted in BUS, mid-waitrequest -> m_read=0 immediately, no rsp_valid afterward; next command after reset completes normally.
- With AMASTER_MM_TIMEOUT_EN, TIMEOUT=4, waitrequest stuck at 1 -> abort on the 4th stall edge, rsp_err=1, rsp_rdata=0; without the macro, no response is produced after 300 cycles.
- Back-to-back: two commands with cmd_valid held high -> second strobe starts 3 cycles after the first with zero waits; m_read and m_write never both 1.
